cpu_dcache_rd: RTL and testbench

- Direct-mapped, one-word-per-line, write-through read cache between the CPU load/store unit and the data write buffer.
- Cached read hits are served locally. Read misses, uncached accesses and all writes are forwarded downstream over the same request/ready bus.
- Writes always go downstream; the line is updated on a hit. The write buffer's own "reads wait for queued writes" rule keeps ordering correct.

---
 rtl/cpu_dcache_rd.sv | 268 ++++++++++++++++++++++++++
 tb/tb_cpu_dcache_rd.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dcache_rd.sv
//==============================================================================
// Module      : cpu_dcache_rd
// Description : Direct-mapped, one-word-per-line, write-through data cache
//               between the CPU load/store unit and the data write buffer.
//               Cached read hits are answered locally. Read misses, uncached
//               accesses and every write go downstream over one
//               request/ready bus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   i_clock, i_reset    : clock, synchronous active-high reset
//   i_request / o_ready : CPU request (held until ready) / 1-cycle completion
//   i_rw                : 0 read, 1 write
//   i_address           : byte address (bits [1:0] ignored for lookup)
//   i_wdata, i_wmask    : write data and byte enables
//   i_cached            : 1 = cacheable region
//   o_rdata             : read data, valid with o_ready on reads
//   o_bus_*             : downstream request, direction, address, data, mask,
//                         cacheable flag
//   i_bus_ready         : downstream completion
//   i_bus_rdata         : downstream read data
//==============================================================================
`default_nettype none

module cpu_dcache_rd #(
    parameter int SIZE = 10
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_rw,
    input  logic        i_request,
    output logic        o_ready,
    input  logic [31:0] i_address,
    output logic [31:0] o_rdata,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    input  logic        i_cached,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    output logic        o_bus_cached
);

    localparam int c_lines  = 2 ** SIZE;
    localparam int c_tag_w  = 30 - SIZE;
    // Line layout: {valid, tag, data}
    localparam int c_line_w = 1 + c_tag_w + 32;

    typedef enum logic [2:0] {
        S_FLUSH  = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_FILL   = 3'd3,
        S_PASS   = 3'd4,
        S_WRITE  = 3'd5
    } state_t;

    state_t              r_state_q;
    state_t              w_state_d;
    logic [SIZE-1:0]     r_flush_cnt_q;
    logic [SIZE-1:0]     w_flush_cnt_d;
    logic                r_hit_q;
    logic                w_hit_d;

    // Single-port line storage with registered read output
    logic [c_line_w-1:0] r_mem [c_lines];
    logic [c_line_w-1:0] r_line_q;

    logic                w_ram_en;
    logic                w_ram_we;
    logic [SIZE-1:0]     w_ram_addr;
    logic [c_line_w-1:0] w_ram_wdata;

    logic [SIZE-1:0]     w_index;
    logic [c_tag_w-1:0]  w_tag;
    logic                w_line_valid;
    logic [c_tag_w-1:0]  w_line_tag;
    logic [31:0]         w_line_data;
    logic                w_hit;
    logic [31:0]         w_merged;

    assign w_index      = i_address[SIZE+1:2];
    assign w_tag        = i_address[31:SIZE+2];
    assign w_line_valid = r_line_q[c_line_w-1];
    assign w_line_tag   = r_line_q[32 +: c_tag_w];
    assign w_line_data  = r_line_q[31:0];
    assign w_hit        = w_line_valid && (w_line_tag == w_tag);

    // Byte merge of the write data into the line captured during LOOKUP.
    // r_line_q is not re-read in WRITE, so it still holds that line.
    always_comb begin
        w_merged = w_line_data;
        for (int b = 0; b < 4; b++) begin
            if (i_wmask[b]) begin
                w_merged[8*b +: 8] = i_wdata[8*b +: 8];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Line RAM: one access per cycle, either a read or a write
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (w_ram_en) begin
            if (w_ram_we) begin
                r_mem[w_ram_addr] <= w_ram_wdata;
            end else begin
                r_line_q <= r_mem[w_ram_addr];
            end
        end
    end

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state_q     <= S_FLUSH;
            r_flush_cnt_q <= '0;
            r_hit_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_flush_cnt_q <= w_flush_cnt_d;
            r_hit_q       <= w_hit_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next state, RAM control and outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_flush_cnt_d = r_flush_cnt_q;
        w_hit_d       = r_hit_q;

        w_ram_en      = 1'b0;
        w_ram_we      = 1'b0;
        w_ram_addr    = w_index;
        w_ram_wdata   = '0;

        o_ready       = 1'b0;
        o_rdata       = '0;
        o_bus_rw      = 1'b0;
        o_bus_request = 1'b0;
        o_bus_address = '0;
        o_bus_wdata   = '0;
        o_bus_wmask   = '0;
        o_bus_cached  = 1'b0;

        case (r_state_q)
            S_FLUSH: begin
                w_ram_en      = 1'b1;
                w_ram_we      = 1'b1;
                w_ram_addr    = r_flush_cnt_q;
                w_ram_wdata   = '0;
                w_flush_cnt_d = r_flush_cnt_q + 1'b1;
                if (r_flush_cnt_q == '1) begin
                    w_state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (i_request) begin
                    if (i_cached) begin
                        w_ram_en  = 1'b1;
                        w_state_d = S_LOOKUP;
                    end else begin
                        w_state_d = S_PASS;
                    end
                end
            end

            S_LOOKUP: begin
                if (!i_rw) begin
                    if (w_hit) begin
                        o_ready   = 1'b1;
                        o_rdata   = w_line_data;
                        w_state_d = S_IDLE;
                    end else begin
                        w_state_d = S_FILL;
                    end
                end else begin
                    w_hit_d   = w_hit;
                    w_state_d = S_WRITE;
                end
            end

            S_FILL: begin
                o_bus_request = 1'b1;
                o_bus_rw      = 1'b0;
                o_bus_address = i_address;
                o_bus_cached  = 1'b1;
                if (i_bus_ready) begin
                    o_ready     = 1'b1;
                    o_rdata     = i_bus_rdata;
                    w_ram_en    = 1'b1;
                    w_ram_we    = 1'b1;
                    w_ram_wdata = {1'b1, w_tag, i_bus_rdata};
                    w_state_d   = S_IDLE;
                end
            end

            S_PASS: begin
                o_bus_request = 1'b1;
                o_bus_rw      = i_rw;
                o_bus_address = i_address;
                o_bus_wdata   = i_wdata;
                o_bus_wmask   = i_wmask;
                o_bus_cached  = 1'b0;
                o_ready       = i_bus_ready;
                o_rdata       = i_bus_rdata;
                if (i_bus_ready) begin
                    w_state_d = S_IDLE;
                end
            end

            S_WRITE: begin
                o_bus_request = 1'b1;
                o_bus_rw      = 1'b1;
                o_bus_address = i_address;
                o_bus_wdata   = i_wdata;
                o_bus_wmask   = i_wmask;
                o_bus_cached  = 1'b1;
                if (i_bus_ready) begin
                    o_ready   = 1'b1;
                    w_state_d = S_IDLE;
                    if (r_hit_q) begin
                        w_ram_en    = 1'b1;
                        w_ram_we    = 1'b1;
                        w_ram_wdata = {1'b1, w_tag, w_merged};
                    end else if (i_wmask == 4'hF) begin
                        // Only a full-word miss can allocate: a partial
                        // write has no valid bytes to fill the rest.
                        w_ram_en    = 1'b1;
                        w_ram_we    = 1'b1;
                        w_ram_wdata = {1'b1, w_tag, i_wdata};
                    end
                end
            end

            default: begin
                w_state_d = S_FLUSH;
            end
        endcase

        // Reset wins in the same cycle: outputs drop at once (abandoning any
        // downstream transaction) and the RAM is left untouched.
        if (i_reset) begin
            w_ram_en      = 1'b0;
            w_ram_we      = 1'b0;
            o_ready       = 1'b0;
            o_rdata       = '0;
            o_bus_rw      = 1'b0;
            o_bus_request = 1'b0;
            o_bus_address = '0;
            o_bus_wdata   = '0;
            o_bus_wmask   = '0;
            o_bus_cached  = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_dcache_rd.sv
//==============================================================================
// Module      : tb_cpu_dcache_rd
// Description : Directed self-checking bench for cpu_dcache_rd (SIZE=4).
//               Index = addr[5:2], tag = addr[31:6].
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cpu_dcache_rd;

    logic        clk;
    logic        i_reset;
    logic        i_rw;
    logic        i_request;
    logic        o_ready;
    logic [31:0] i_address;
    logic [31:0] o_rdata;
    logic [31:0] i_wdata;
    logic [3:0]  i_wmask;
    logic        i_cached;
    logic        o_bus_rw;
    logic        o_bus_request;
    logic        i_bus_ready;
    logic [31:0] o_bus_address;
    logic [31:0] i_bus_rdata;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wmask;
    logic        o_bus_cached;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the last transaction
    logic [31:0] t_rdata;
    logic [31:0] t_addr;
    logic [3:0]  t_mask;
    logic        t_cached;
    logic        t_rw;
    logic        t_done;
    int          t_lat;
    int          t_nbus;

    cpu_dcache_rd #(.SIZE(4)) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_rw          (i_rw),
        .i_request     (i_request),
        .o_ready       (o_ready),
        .i_address     (i_address),
        .o_rdata       (o_rdata),
        .i_wdata       (i_wdata),
        .i_wmask       (i_wmask),
        .i_cached      (i_cached),
        .o_bus_rw      (o_bus_rw),
        .o_bus_request (o_bus_request),
        .i_bus_ready   (i_bus_ready),
        .o_bus_address (o_bus_address),
        .i_bus_rdata   (i_bus_rdata),
        .o_bus_wdata   (o_bus_wdata),
        .o_bus_wmask   (o_bus_wmask),
        .o_bus_cached  (o_bus_cached)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU transaction. Entered at posedge+1; returns at posedge+1 of the
    // cycle after o_ready with i_request low. The downstream model raises
    // i_bus_ready 'dly' cycles after it first sees o_bus_request.
    task automatic xact(input logic rw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic cached, input logic [31:0] bus_data,
                        input int dly);
        int wait_cnt;
        wait_cnt = 0;
        t_done = 1'b0; t_lat = 0; t_nbus = 0; t_rdata = '0;
        t_addr = '0; t_mask = '0; t_cached = 1'b0; t_rw = 1'b0;
        i_request = 1'b1; i_rw = rw; i_address = addr;
        i_wdata = wdata; i_wmask = wmask; i_cached = cached;
        for (int c = 0; c < 64 && !t_done; c++) begin
            #1;
            if (o_bus_request) begin
                if (wait_cnt == 0) begin
                    t_nbus++;
                    t_addr   = o_bus_address;
                    t_mask   = o_bus_wmask;
                    t_cached = o_bus_cached;
                    t_rw     = o_bus_rw;
                end
                if (wait_cnt == dly) begin
                    i_bus_ready = 1'b1;
                    i_bus_rdata = bus_data;
                end
                wait_cnt++;
            end
            #1;
            if (o_ready) begin
                t_done  = 1'b1;
                t_rdata = o_rdata;
                t_lat   = c + 1;
            end
            @(posedge clk); #1;
            i_bus_ready = 1'b0;
            i_bus_rdata = '0;
        end
        i_request = 1'b0; i_rw = 1'b0; i_address = '0;
        i_wdata = '0; i_wmask = '0; i_cached = 1'b0;
        chk("xact_completed", {31'd0, t_done}, 32'd1);
    endtask

    // o_ready must not linger into the cycle after completion
    task automatic chk_idle(input string tag);
        #1;
        chk(tag, {31'd0, o_ready}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        int first;
        logic seen;

        i_reset = 1'b1; i_rw = 1'b0; i_request = 1'b0; i_address = '0;
        i_wdata = '0; i_wmask = '0; i_cached = 1'b0;
        i_bus_ready = 1'b0; i_bus_rdata = '0;

        // ---- Reset state: everything driven low while reset is high
        #1;
        chk("rst_ready",    {31'd0, o_ready},       32'd0);
        chk("rst_bus_req",  {31'd0, o_bus_request}, 32'd0);
        chk("rst_rdata",    o_rdata,                32'd0);
        chk("rst_bus_addr", o_bus_address,          32'd0);

        // ---- Request issued during FLUSH waits until the flush ends
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_request = 1'b1; i_rw = 1'b0; i_address = 32'h0000_0100; i_cached = 1'b1;
        quiet = 0; first = -1;
        for (int c = 0; c < 40 && first < 0; c++) begin
            #1;
            if (c < 16 && (o_ready || o_bus_request)) quiet++;
            if (o_bus_request) begin
                first = c;
                i_bus_ready = 1'b1;
                i_bus_rdata = 32'hCAFE_F00D;
                #1;
                chk("flush_req_ready", {31'd0, o_ready}, 32'd1);
                chk("flush_req_rdata", o_rdata, 32'hCAFE_F00D);
            end
            @(posedge clk); #1;
            i_bus_ready = 1'b0; i_bus_rdata = '0;
        end
        i_request = 1'b0; i_address = '0; i_cached = 1'b0;
        chk("flush_quiet", 32'(quiet), 32'd0);
        // 16 FLUSH + IDLE + LOOKUP, then FILL
        chk("flush_first_bus_req", 32'(first), 32'd18);

        // ---- Cold read miss on 0x40 (index 0, evicts 0x100), 3-cycle bus
        xact(1'b0, 32'h0000_0040, '0, 4'h0, 1'b1, 32'hDEAD_BEEF, 3);
        chk("miss_rdata",  t_rdata, 32'hDEAD_BEEF);
        chk("miss_nbus",   32'(t_nbus), 32'd1);
        chk("miss_lat",    32'(t_lat), 32'd6);
        chk("miss_addr",   t_addr, 32'h0000_0040);
        chk("miss_cached", {31'd0, t_cached}, 32'd1);
        chk("miss_rw",     {31'd0, t_rw}, 32'd0);
        chk_idle("miss_ready_single");

        // ---- Repeat read hits locally
        xact(1'b0, 32'h0000_0040, '0, 4'h0, 1'b1, 32'h0BAD_0BAD, 0);
        chk("hit_rdata", t_rdata, 32'hDEAD_BEEF);
        chk("hit_nbus",  32'(t_nbus), 32'd0);
        chk("hit_lat",   32'(t_lat), 32'd2);
        chk_idle("hit_ready_single");

        // ---- Partial write hit merges low half-word
        xact(1'b1, 32'h0000_0040, 32'h1122_3344, 4'b0011, 1'b1, '0, 1);
        chk("wr_hit_nbus", 32'(t_nbus), 32'd1);
        chk("wr_hit_mask", {28'd0, t_mask}, 32'h3);
        chk("wr_hit_rw",   {31'd0, t_rw}, 32'd1);
        chk("wr_hit_cached", {31'd0, t_cached}, 32'd1);
        xact(1'b0, 32'h0000_0040, '0, 4'h0, 1'b1, 32'h0BAD_0BAD, 0);
        chk("merge_rdata", t_rdata, 32'hDEAD_3344);
        chk("merge_nbus",  32'(t_nbus), 32'd0);

        // ---- Aliasing: 0x80 shares index 0 with 0x40
        xact(1'b0, 32'h0000_0080, '0, 4'h0, 1'b1, 32'h8080_8080, 0);
        chk("alias_nbus",  32'(t_nbus), 32'd1);
        chk("alias_rdata", t_rdata, 32'h8080_8080);
        xact(1'b0, 32'h0000_0040, '0, 4'h0, 1'b1, 32'h4040_4040, 2);
        chk("alias_back_nbus",  32'(t_nbus), 32'd1);
        chk("alias_back_rdata", t_rdata, 32'h4040_4040);

        // ---- Uncached pass-through, never allocated
        xact(1'b0, 32'h8000_0000, '0, 4'h0, 1'b0, 32'h1234_5678, 2);
        chk("unc_cached", {31'd0, t_cached}, 32'd0);
        chk("unc_rdata",  t_rdata, 32'h1234_5678);
        chk("unc_addr",   t_addr, 32'h8000_0000);
        chk("unc_lat",    32'(t_lat), 32'd4);
        xact(1'b0, 32'h8000_0000, '0, 4'h0, 1'b0, 32'h8765_4321, 0);
        chk("unc_again_nbus",  32'(t_nbus), 32'd1);
        chk("unc_again_rdata", t_rdata, 32'h8765_4321);

        // ---- Partial write miss does not allocate
        xact(1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'b0111, 1'b1, '0, 0);
        chk("pwmiss_nbus", 32'(t_nbus), 32'd1);
        chk("pwmiss_mask", {28'd0, t_mask}, 32'h7);
        xact(1'b0, 32'h0000_0044, '0, 4'h0, 1'b1, 32'h4444_4444, 0);
        chk("pwmiss_read_nbus",  32'(t_nbus), 32'd1);
        chk("pwmiss_read_rdata", t_rdata, 32'h4444_4444);

        // ---- Full write miss allocates
        xact(1'b1, 32'h0000_0048, 32'hA5A5_A5A5, 4'hF, 1'b1, '0, 0);
        chk("fwmiss_nbus", 32'(t_nbus), 32'd1);
        xact(1'b0, 32'h0000_0048, '0, 4'h0, 1'b1, 32'h0BAD_0BAD, 0);
        chk("fwmiss_read_nbus",  32'(t_nbus), 32'd0);
        chk("fwmiss_read_rdata", t_rdata, 32'hA5A5_A5A5);

        // ---- Reset in the middle of a fill
        i_request = 1'b1; i_rw = 1'b0; i_address = 32'h0000_004C; i_cached = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (o_bus_request) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("rstfill_started", {31'd0, seen}, 32'd1);
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_request = 1'b0; i_address = '0; i_cached = 1'b0;
        #1;
        chk("rstfill_bus_req", {31'd0, o_bus_request}, 32'd0);
        chk("rstfill_ready",   {31'd0, o_ready}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        xact(1'b0, 32'h0000_0040, '0, 4'h0, 1'b1, 32'h5555_AAAA, 0);
        chk("post_flush_nbus",  32'(t_nbus), 32'd1);
        chk("post_flush_rdata", t_rdata, 32'h5555_AAAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
